hack_dmem_responder: RTL
========================

HACK_DMEM_RESPONDER -- requirements
Module: hack_dmem_responder

Interface
REQ-001 Parameter LOG_DEPTH, default 16: write-log FIFO entries (power of two, >=2).
REQ-002 Parameter DROP_W, default 16: width of dropped-write counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  CPU data-memory write strobe.
REQ-006 ram_address  input  15  CPU data address.
REQ-007 cpu_out_m  input  16  CPU write data.
REQ-008 in_m  output  16  read data for ram_address, combinational.
REQ-009 kbd_valid  input  1  keyboard code load strobe.
REQ-010 kbd_code  input  16  keyboard scan code.
REQ-011 log_valid  output  1  write-log head entry available.
REQ-012 log_ready  input  1  consumer accepts head entry.
REQ-013 log_addr  output  15  head entry address.
REQ-014 log_data  output  16  head entry data.
REQ-015 log_drop_cnt  output  DROP_W  writes lost to full log.
REQ-016 bad_addr_cnt  output  16  accesses with we=1 to unmapped or read-only addresses.

Function
REQ-017 Map: 0x0000-0x3FFF RAM (16K words); 0x4000-0x5FFF SCREEN (8K words); 0x6000 KBD; 0x6001-0x7FFF unmapped.
REQ-018 we=1 with Reset=0 writes cpu_out_m into RAM/SCREEN at the rising edge; the new value is visible on in_m from the next cycle.
REQ-019 in_m: RAM/SCREEN word at ram_address; KBD register at 0x6000; 0 for unmapped; same-cycle, no latency.
REQ-020 KBD register loads kbd_code on kbd_valid=1; holds otherwise; CPU writes to 0x6000 leave it unchanged.
REQ-021 we=1 to 0x6000 or unmapped increments bad_addr_cnt, saturating at 0xFFFF.
REQ-022 Every write with we=1 and Reset=0, any address, pushes {ram_address, cpu_out_m} into the log FIFO in issue order.
REQ-023 Pop occurs when log_valid=1 and log_ready=1; log_addr/log_data present the oldest entry while log_valid=1; entry held stable while log_ready=0.
REQ-024 Empty: log_valid=0; log_ready ignored; log_addr/log_data are don't-care.
REQ-025 Full without pop: push dropped, log_drop_cnt increments, saturating at all-ones.
REQ-026 Full with simultaneous pop: push accepted, occupancy unchanged, no drop.
REQ-027 Empty with push: entry visible (log_valid=1) the following cycle; no fall-through.
REQ-028 Read/write pointers wrap modulo LOG_DEPTH; occupancy counter has log2(LOG_DEPTH)+1 bits.

Reset
REQ-029 While Reset=1: FIFO emptied (log_valid=0), KBD register=0, log_drop_cnt=0, bad_addr_cnt=0; we and kbd_valid ignored.
REQ-030 RAM and SCREEN contents are not reset and survive Reset asserted mid-operation.
REQ-031 Log entries pending at Reset assertion are discarded; first post-reset push starts at pointer 0.

Structure
REQ-032 Package hack_mem_pkg holds map constants (RAM_BASE, SCREEN_BASE, KBD_ADDR), region enum, and log-entry struct {addr[14:0], data[15:0]}.
REQ-033 FIFO is sub-module hack_log_fifo (push/full/pop/valid, drop counting in parent).

Verification
REQ-034 Write 0x1234 to 0x0010, then read 0x0010 -> in_m=0x1234 next cycle; log yields {0x0010,0x1234}.
REQ-035 kbd_valid with 0x0041, read 0x6000 -> 0x0041; write 0xFFFF to 0x6000 -> KBD still 0x0041, bad_addr_cnt=1.
REQ-036 log_ready=0, 17 writes with LOG_DEPTH=16 -> log_drop_cnt=1; drain returns first 16 in order.
REQ-037 Full FIFO, write with log_ready=1 same cycle -> no drop, occupancy stays 16, order preserved.
REQ-038 Write 0xBEEF to 0x4000, assert Reset 1 cycle with 3 logged entries -> log_valid=0, counters 0, in_m at 0x4000=0xBEEF.
REQ-039 Read 0x7000 -> in_m=0; write 0x7000 -> no memory change, bad_addr_cnt increments, entry logged.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory responder: address map,
// region decode and the write-log entry payload.
package hack_mem_pkg;

   localparam int unsigned ADDR_W       = 15;
   localparam int unsigned DATA_W       = 16;
   localparam int unsigned RAM_WORDS    = 16384;
   localparam int unsigned SCREEN_WORDS = 8192;
   localparam int unsigned RAM_IDX_W    = $clog2(RAM_WORDS);
   localparam int unsigned SCREEN_IDX_W = $clog2(SCREEN_WORDS);

   localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
   localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
   localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_SCREEN,
      REGION_KBD,
      REGION_UNMAPPED
   } region_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } log_entry_t;

   // Map a CPU address onto its region; everything above KBD is unmapped.
   function automatic region_e decode_region(input logic [ADDR_W-1:0] a);
      region_e r;
      if (a < SCREEN_BASE)      r = REGION_RAM;
      else if (a < KBD_ADDR)    r = REGION_SCREEN;
      else if (a == KBD_ADDR)   r = REGION_KBD;
      else                      r = REGION_UNMAPPED;
      return r;
   endfunction

endpackage

// File: rtl/hack_log_fifo.sv
// Write-log FIFO: registered storage, no fall-through, push accepted when
// full only if a pop happens in the same cycle.
// Ports: clk/rst (sync active-high), push/push_entry, pop, full, valid, head.
module hack_log_fifo
   import hack_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  log_entry_t push_entry,
   input  logic       pop,
   output logic       full,
   output logic       valid,
   output log_entry_t head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   log_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok_c;
   logic             push_ok_c;

   assign valid = (count_q != '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
   always_comb begin
      pop_ok_c  = pop && valid;
      push_ok_c = push && (!full || pop_ok_c);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (!rst && push_ok_c) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/hack_dmem_responder.sv
// Hack data-memory responder: RAM + SCREEN + KBD register with a
// combinational read port, plus a write log and error counters.
// Ports: Clk/Reset (sync active-high); CPU side we/ram_address/cpu_out_m/in_m;
// keyboard kbd_valid/kbd_code; log stream log_valid/log_ready/log_addr/log_data;
// counters log_drop_cnt and bad_addr_cnt.
module hack_dmem_responder
   import hack_mem_pkg::*;
#(
   parameter int unsigned LOG_DEPTH = 16,
   parameter int unsigned DROP_W    = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] cpu_out_m,
   output logic [DATA_W-1:0] in_m,
   input  logic              kbd_valid,
   input  logic [DATA_W-1:0] kbd_code,
   output logic              log_valid,
   input  logic              log_ready,
   output logic [ADDR_W-1:0] log_addr,
   output logic [DATA_W-1:0] log_data,
   output logic [DROP_W-1:0] log_drop_cnt,
   output logic [15:0]       bad_addr_cnt
);

   logic [DATA_W-1:0] ram_q    [RAM_WORDS];
   logic [DATA_W-1:0] screen_q [SCREEN_WORDS];

   logic [DATA_W-1:0] kbd_q, kbd_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [15:0]       bad_q, bad_d;

   region_e                 region_c;
   logic [RAM_IDX_W-1:0]    ram_idx_c;
   logic [SCREEN_IDX_W-1:0] scr_idx_c;
   logic                    fifo_full;
   log_entry_t              push_entry_c;
   log_entry_t              head;
   logic                    drop_c;

   assign region_c     = decode_region(ram_address);
   assign ram_idx_c    = RAM_IDX_W'(ram_address - RAM_BASE);
   assign scr_idx_c    = SCREEN_IDX_W'(ram_address - SCREEN_BASE);
   assign push_entry_c = '{addr: ram_address, data: cpu_out_m};

   // Memory contents deliberately survive Reset; only writes are gated by it.
   always_ff @(posedge Clk) begin
      if (!Reset && we) begin
         if (region_c == REGION_RAM)    ram_q[ram_idx_c]    <= cpu_out_m;
         if (region_c == REGION_SCREEN) screen_q[scr_idx_c] <= cpu_out_m;
      end
   end

   // Same-cycle read mux.
   always_comb begin
      in_m = '0;
      unique case (region_c)
         REGION_RAM:      in_m = ram_q[ram_idx_c];
         REGION_SCREEN:   in_m = screen_q[scr_idx_c];
         REGION_KBD:      in_m = kbd_q;
         REGION_UNMAPPED: in_m = '0;
         default:         in_m = '0;
      endcase
   end

   hack_log_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log_fifo (
      .clk        (Clk),
      .rst        (Reset),
      .push       (we),
      .push_entry (push_entry_c),
      .pop        (log_ready),
      .full       (fifo_full),
      .valid      (log_valid),
      .head       (head)
   );

   assign log_addr = head.addr;
   assign log_data = head.data;

   // A push is lost only when the log is full and nothing drains this cycle.
   assign drop_c = we && fifo_full && !(log_ready && log_valid);

   // Keyboard register and saturating error counters.
   always_comb begin
      kbd_d  = kbd_q;
      drop_d = drop_q;
      bad_d  = bad_q;
      if (kbd_valid) kbd_d = kbd_code;
      if (drop_c && !(&drop_q)) drop_d = drop_q + DROP_W'(1);
      if (we && (region_c == REGION_KBD || region_c == REGION_UNMAPPED) && !(&bad_q))
         bad_d = bad_q + 16'(1);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         kbd_q  <= '0;
         drop_q <= '0;
         bad_q  <= '0;
      end else begin
         kbd_q  <= kbd_d;
         drop_q <= drop_d;
         bad_q  <= bad_d;
      end
   end

   assign log_drop_cnt = drop_q;
   assign bad_addr_cnt = bad_q;

endmodule
